div_unit: RTL
=============

# div_unit

Iterative 32-bit integer divider for the CPU's execute stage. It implements MIPS DIV/DIVU by running one shared 33-bit trial-subtract (radix-2 restoring) per cycle for 32 cycles. While it works it holds the pipeline stall line high, and it returns quotient (LO) and remainder (HI) with a one-cycle valid pulse. The execute stage uses it as a shared multi-cycle resource: one operation at a time, cancellable by an exception flush.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; only 32 is supported.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a divide; sampled only in IDLE.
- `signed_div`  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- `dividend`  in  32  sampled with start.
- `divisor`  in  32  sampled with start.
- `cancel`  in  1  flush; aborts any operation in progress.
- `stall`  out  1  pipeline stall request.
- `valid`  out  1  one-cycle result strobe.
- `quotient`  out  32  to LO.
- `remainder`  out  32  to HI.

## Operation
- States: IDLE, BUSY, FIX, DONE. Encoding is defined in the package.
- IDLE, start=1, cancel=0, divisor≠0:
  - Latch |dividend| and |divisor| (absolute value only if signed_div).
  - Latch sign flags: q_neg = sign(dividend) XOR sign(divisor); r_neg = sign(dividend).
  - Clear the 6-bit iteration counter and the 33-bit partial remainder. Go to BUSY.
- IDLE, start=1, cancel=0, divisor=0: go directly to DONE with quotient=0xFFFFFFFF and remainder=dividend (raw, unmodified).
- BUSY, each cycle:
  - Shift the next dividend MSB into the partial remainder.
  - Compute trial = partial − {1'b0,|divisor|} over 33 bits.
  - If trial is non-negative, keep trial and shift in quotient bit 1; otherwise keep partial and shift in 0.
  - After counter reaches 31 (32 iterations), go to FIX.
- FIX:
  - Negate the quotient if q_neg; negate the remainder if r_neg.
  - Register both into the outputs. Go to DONE.
- DONE: valid=1 for this cycle only. Go to IDLE.
- Width rule: the magnitude of 0x80000000 is 0x80000000 as unsigned. Consequently signed 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0, with no trap.
- start outside IDLE is ignored, with no queuing. The requester must hold start until stall falls.
- cancel in any state: next state is IDLE, no valid pulse, outputs keep their previous values. cancel together with start in IDLE: cancel wins, and the request is not accepted.
- quotient/remainder hold their last values until the next FIX or divide-by-zero entry into DONE.
- Reset values:
  - state = IDLE, counter = 0
  - stall = 0, valid = 0
  - quotient = 0, remainder = 0

## Timing
- Cycle 0 is the cycle where start is sampled high in IDLE.
- Normal latency:
  - BUSY covers cycles 1–32.
  - FIX is cycle 33.
  - DONE is cycle 34: valid=1, results stable.
- Divide by zero: DONE is cycle 1.
- stall is high combinationally in cycle 0 (start & IDLE & ~cancel), and registered-state high in BUSY and FIX. stall is low in DONE and IDLE.
- Back-to-back: a new start may be presented in the cycle after DONE.
- rst overrides cancel and start. rst in mid-operation returns to IDLE at the next edge.

## Structure
- Shared package `cpu_pkg` holds:
  - the state enum (IDLE/BUSY/FIX/DONE)
  - `DIV_ITERS` = 32
  - `DIV_BY_ZERO_Q` = 32'hFFFFFFFF
- One sub-module, `div_step`: combinational 33-bit trial subtract.
  - Inputs: partial remainder, divisor magnitude, incoming dividend bit.
  - Outputs: next partial remainder, quotient bit.
  - Instantiated once and reused every BUSY cycle.
- FSM, counter, operand registers and sign fixup live in `div_unit`.

## Test plan
- DIVU 100 / 7 (0x64 / 0x7), start in cycle 0 → stall high cycles 0–33; valid only in cycle 34; quotient=14 (0x0000000E), remainder=2.
- DIV −7 / 2 (0xFFFFFFF9 / 0x00000002) → quotient=0xFFFFFFFD (−3), remainder=0xFFFFFFFF (−1). DIV 7 / −2 → quotient=0xFFFFFFFD, remainder=1.
- DIV 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0. DIVU with the same operands → quotient=0, remainder=0x80000000.
- Divide by zero, dividend 0x12345678 → valid in cycle 1, stall high only in cycle 0; quotient=0xFFFFFFFF, remainder=0x12345678.
- Cancel pulse in cycle 10 of a DIVU → IDLE in cycle 11, no valid, outputs unchanged. A new start in cycle 11 is accepted, with valid in cycle 45. A start asserted in cycle 5 of a running op is ignored.
- rst in cycle 20 → cycle 21: stall=0, valid=0, quotient=0, remainder=0. Also: start+cancel in the same IDLE cycle → stall=0, no operation begins.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared divider state encoding, constants and operand helper
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

    localparam int          DIV_ITERS     = 32;
    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFFFFFF;

    // 0x80000000 maps onto itself, which reads correctly as an unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division iteration: shift in a dividend bit, trial subtract
module div_step (
    input  logic [32:0] partial_i,
    input  logic [31:0] divisor_i,
    input  logic        dividend_bit_i,
    output logic [32:0] partial_o,
    output logic        quotient_bit_o
);
    logic [32:0] shifted;
    logic [32:0] trial;
    logic        unused_partial_msb;

    // The partial remainder is always below the divisor, so its top bit is zero.
    assign unused_partial_msb = partial_i[32];
    assign shifted            = {partial_i[31:0], dividend_bit_i};
    assign trial              = shifted - {1'b0, divisor_i};

    always_comb begin
        quotient_bit_o = ~trial[32];
        partial_o      = trial[32] ? shifted : trial;
    end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative 32-bit DIV/DIVU with pipeline stall, cancel and sign fixup
module div_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    output logic             stall,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    div_state_e  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [32:0] part_q, part_d;
    logic [31:0] dvd_q, dvd_d;
    logic [31:0] dsr_q, dsr_d;
    logic [31:0] quo_q, quo_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic [31:0] quotient_q, quotient_d;
    logic [31:0] remainder_q, remainder_d;

    logic [32:0] step_part;
    logic        step_qbit;

    div_step u_step (
        .partial_i      (part_q),
        .divisor_i      (dsr_q),
        .dividend_bit_i (dvd_q[31]),
        .partial_o      (step_part),
        .quotient_bit_o (step_qbit)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        part_d      = part_q;
        dvd_d       = dvd_q;
        dsr_d       = dsr_q;
        quo_d       = quo_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        if (cancel) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient_d  = DIV_BY_ZERO_Q;
                            remainder_d = dividend;
                            state_d     = ST_DONE;
                        end else begin
                            dvd_d   = abs32(dividend, signed_div);
                            dsr_d   = abs32(divisor, signed_div);
                            q_neg_d = signed_div & (dividend[31] ^ divisor[31]);
                            r_neg_d = signed_div & dividend[31];
                            cnt_d   = '0;
                            part_d  = '0;
                            quo_d   = '0;
                            state_d = ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    part_d = step_part;
                    quo_d  = {quo_q[30:0], step_qbit};
                    dvd_d  = {dvd_q[30:0], 1'b0};
                    cnt_d  = cnt_q + 6'd1;
                    if (cnt_q == 6'(DIV_ITERS - 1)) begin
                        state_d = ST_FIX;
                    end
                end
                ST_FIX: begin
                    quotient_d  = q_neg_q ? (~quo_q + 32'd1) : quo_q;
                    remainder_d = r_neg_q ? (~part_q[31:0] + 32'd1) : part_q[31:0];
                    state_d     = ST_DONE;
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            part_q      <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            quo_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            part_q      <= part_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            quo_q       <= quo_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    // Stall goes up in the request cycle itself so the pipeline freezes before BUSY.
    assign stall     = ((state_q == ST_IDLE) & start & ~cancel) |
                       (state_q == ST_BUSY) | (state_q == ST_FIX);
    assign valid     = (state_q == ST_DONE);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule
